// File: rtl/startup_seq_ctrl.sv
// Startup sequencer: filters PLL lock, then releases GSR/PRLD, GTS and GWE in order.
// Every output comes straight from a flop; the sequence can be rerun by restart or lock loss.
module startup_seq_ctrl #(
  parameter int LOCK_FILT  = 8,
  parameter int ROC_CYCLES = 100,
  parameter int TOC_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       gsr_o,
  output logic       prld_o,
  output logic       gts_o,
  output logic       gwe_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_LOCK = 3'd0,
    S_ROC  = 3'd1,
    S_TOC  = 3'd2,
    S_GWE  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_FILT);
  localparam logic [CNT_W-1:0] ROC_N  = CNT_W'(ROC_CYCLES);
  localparam logic [CNT_W-1:0] TOC_N  = CNT_W'(TOC_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             gsr_q, gsr_d, gts_q, gts_d, gwe_q, gwe_d, done_q, done_d;
  logic             abort;

  // Saturating increment: the counter never wraps back into a match.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign abort   = restart || (!pll_locked && (state_q != S_LOCK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gsr_d   = gsr_q;
    gts_d   = gts_q;
    gwe_d   = gwe_q;
    done_d  = done_q;
    if (abort) begin
      state_d = S_LOCK;
      cnt_d   = '0;
      gsr_d   = 1'b1;
      gts_d   = 1'b1;
      gwe_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_LOCK: begin
          gsr_d  = 1'b1;
          gts_d  = 1'b1;
          gwe_d  = 1'b0;
          done_d = 1'b0;
          if (!pll_locked) begin
            cnt_d = '0;
          end else if (cnt_inc == LOCK_N) begin
            state_d = S_ROC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ROC: begin
          gsr_d = 1'b1;
          gts_d = 1'b1;
          if (cnt_inc == ROC_N) begin
            gsr_d = 1'b0;
            cnt_d = '0;
            if (TOC_CYCLES == 0) begin
              gts_d   = 1'b0;
              state_d = S_GWE;
            end else begin
              state_d = S_TOC;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_TOC: begin
          gsr_d = 1'b0;
          gts_d = 1'b1;
          if (cnt_inc == TOC_N) begin
            gts_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_GWE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        // First edge here raises gwe; the following edge moves on and raises done.
        S_GWE: begin
          if (!gwe_q) begin
            gwe_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_LOCK;
          cnt_d   = '0;
          gsr_d   = 1'b1;
          gts_d   = 1'b1;
          gwe_d   = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOCK;
      cnt_q   <= '0;
      gsr_q   <= 1'b1;
      gts_q   <= 1'b1;
      gwe_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gsr_q   <= gsr_d;
      gts_q   <= gts_d;
      gwe_q   <= gwe_d;
      done_q  <= done_d;
    end
  end

  assign gsr_o   = gsr_q;
  assign prld_o  = gsr_q;
  assign gts_o   = gts_q;
  assign gwe_o   = gwe_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_startup_seq_ctrl.sv
// Bench for startup_seq_ctrl: directed scenarios plus random lock/restart traffic
// against a model that tracks edges elapsed since lock acceptance.
module tb_startup_seq_ctrl;

  localparam int LF = 4;
  localparam int RC = 10;
  localparam int TA = 3;
  localparam int TB = 0;

  logic       clk, rst_n, pll_locked, restart;
  logic       gsr_a, prld_a, gts_a, gwe_a, done_a;
  logic       gsr_b, prld_b, gts_b, gwe_b, done_b;
  logic [2:0] st_a, st_b;

  startup_seq_ctrl #(.LOCK_FILT(LF), .ROC_CYCLES(RC), .TOC_CYCLES(TA), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .gsr_o(gsr_a), .prld_o(prld_a), .gts_o(gts_a), .gwe_o(gwe_a), .done_o(done_a),
    .state_o(st_a));

  startup_seq_ctrl #(.LOCK_FILT(LF), .ROC_CYCLES(RC), .TOC_CYCLES(TB), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .gsr_o(gsr_b), .prld_o(prld_b), .gts_o(gts_b), .gwe_o(gwe_b), .done_o(done_b),
    .state_o(st_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: streak of good lock samples, then t = edges since the accepting edge.
  typedef struct { int streak; bit acc; int t; } mdl_t;

  mdl_t ma, mb;
  int   n_chk = 0;
  int   n_pass = 0;
  int   ecnt = 0;

  function automatic mdl_t mstep(input mdl_t m, input bit pll, input bit rs);
    mdl_t r = m;
    if (rs || (!pll && m.acc)) begin
      r.streak = 0; r.acc = 1'b0; r.t = 0;
    end else if (m.acc) begin
      if (m.t < 1000) r.t = m.t + 1;
    end else if (!pll) begin
      r.streak = 0;
    end else begin
      r.streak = m.streak + 1;
      if (r.streak >= LF) begin r.acc = 1'b1; r.t = 0; end
    end
    return r;
  endfunction

  // Expected {state, gsr, prld, gts, gwe, done}.
  function automatic logic [7:0] mout(input mdl_t m, input int toc);
    logic [2:0] s;
    logic g, ts, w, d;
    if (!m.acc) return {3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    g  = (m.t < RC);
    ts = (m.t < RC + toc);
    w  = (m.t >= RC + toc + 1);
    d  = (m.t >= RC + toc + 2);
    if (m.t < RC)            s = 3'd1;
    else if (m.t < RC + toc) s = 3'd2;
    else if (d)              s = 3'd4;
    else                     s = 3'd3;
    return {s, g, g, ts, w, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s (edge %0d): got %h expected %h", tag, ecnt, obs, exp);
  endtask

  task automatic cmp_all();
    chk("toc3_outs", {st_a, gsr_a, prld_a, gts_a, gwe_a, done_a}, mout(ma, TA));
    chk("toc0_outs", {st_b, gsr_b, prld_b, gts_b, gwe_b, done_b}, mout(mb, TB));
  endtask

  task automatic step(input bit pll, input bit rs);
    pll_locked = pll;
    restart    = rs;
    @(posedge clk);
    ma = mstep(ma, pll, rs);
    mb = mstep(mb, pll, rs);
    ecnt++;
    #1;
    cmp_all();
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    ma = '{0, 1'b0, 0};
    mb = '{0, 1'b0, 0};
    ecnt = 0;
    cmp_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bit [7:0] glitch;
    rst_n = 1'b0; pll_locked = 1'b1; restart = 1'b0;
    @(posedge clk); #1;

    // Nominal
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      step(1'b1, 1'b0);
      if (e == 13) chk("nom_gsr13", 32'(gsr_a), 32'd1);
      if (e == 14) begin
        chk("nom_gsr14", 32'(gsr_a), 32'd0);
        chk("toc0_gts14", 32'(gts_b), 32'd0);
      end
      if (e == 15) chk("toc0_gwe15", 32'(gwe_b), 32'd1);
      if (e == 16) chk("nom_gts16", 32'(gts_a), 32'd1);
      if (e == 17) chk("nom_gts17", 32'(gts_a), 32'd0);
      if (e == 18) chk("nom_gwe18", {31'd0, gwe_a}, {31'd0, 1'b1});
      if (e == 18) chk("nom_done18", 32'(done_a), 32'd0);
      if (e == 19) chk("nom_done19", 32'(done_a), 32'd1);
    end

    // Glitchy lock
    do_reset();
    glitch = 8'b1111_0111;
    for (int e = 1; e <= 20; e++) begin
      step((e <= 8) ? glitch[e-1] : 1'b1, 1'b0);
      if (e == 7)  chk("gl_st7", 32'(st_a), 32'd0);
      if (e == 8)  chk("gl_st8", 32'(st_a), 32'd1);
      if (e == 17) chk("gl_gsr17", 32'(gsr_a), 32'd1);
      if (e == 18) chk("gl_gsr18", 32'(gsr_a), 32'd0);
    end

    // Lock loss in S_TOC at edge 15
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      step(e != 15, 1'b0);
      if (e == 15) chk("loss_outs", {29'd0, st_a, gsr_a, gts_a, gwe_a}, {29'd0, 3'd0, 3'b110});
    end

    // Restart in S_DONE
    do_reset();
    for (int e = 1; e <= 20; e++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rs_done", 32'(done_a), 32'd0);
    chk("rs_gsr", 32'(gsr_a), 32'd1);
    for (int e = 1; e <= 16; e++) begin
      step(1'b1, 1'b0);
      if (e == 13) chk("rs_gsr13", 32'(gsr_a), 32'd1);
      if (e == 14) chk("rs_gsr14", 32'(gsr_a), 32'd0);
    end

    // Async reset mid-S_ROC
    do_reset();
    for (int e = 1; e <= 8; e++) step(1'b1, 1'b0);
    chk("ar_pre_st", 32'(st_a), 32'd1);
    do_reset();
    chk("ar_gsr", 32'(gsr_a), 32'd1);

    // Random lock loss / restart traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 99) == 0);
      if (gts_a === 1'b0) chk("inv_gts_gsr", 32'(gsr_a), 32'd0);
      if (done_a === 1'b1) chk("inv_done_gwe", 32'(gwe_a), 32'd1);
      if ((i % 200) == 199) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
